// File: rtl/ysyx_22041071_mul_ctrl_pkg.sv
// Shared definitions for the multiply controller: data width, funct3 codes,
// multiplier sign-mode encodings, FSM state encoding and small decode helpers.
// Pure declarations; no timing or backpressure behaviour of its own.
package ysyx_22041071_mul_ctrl_pkg;

    localparam int XLEN = 64;

    // funct3 codes of the RV64M multiply group handled here
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // m_signed = {src1 signed, src2 signed}; 2'b01 is never produced
    localparam logic [1:0] MSGN_SS = 2'b11;
    localparam logic [1:0] MSGN_SU = 2'b10;
    localparam logic [1:0] MSGN_UU = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Only the four multiply codes are legal, and the word form only with MUL.
    function automatic logic op_legal(input logic [2:0] op, input logic w);
        return (op[2] == 1'b0) && !(w && (op != F3_MUL));
    endfunction

    // A zero operand makes every product zero; the word form only looks at the low half.
    function automatic logic is_zero(input logic w, input logic [XLEN-1:0] x);
        return w ? (x[31:0] == 32'd0) : (x == '0);
    endfunction

    function automatic logic [1:0] signed_sel(input logic [2:0] op);
        logic [1:0] s;
        s = MSGN_UU;
        case (op)
            F3_MUL, F3_MULH: s = MSGN_SS;
            F3_MULHSU:       s = MSGN_SU;
            default:         s = MSGN_UU;
        endcase
        return s;
    endfunction

    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op, input logic w,
                                                   input logic [XLEN-1:0] h,
                                                   input logic [XLEN-1:0] l);
        logic [XLEN-1:0] r;
        r = h;
        if (op == F3_MUL) begin
            r = w ? {{32{l[31]}}, l[31:0]} : l;
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22041071_mul_ctrl_if.sv
// Bundle of the issue handshake, result handshake and multiplier-side signals.
// No logic; slave is the controller's view, master the surrounding EX stage + multiplier.
// Backpressure: in_ready / out_ready / m_ready travel opposite to their valids.
interface ysyx_22041071_mul_ctrl_if;
    import ysyx_22041071_mul_ctrl_pkg::*;

    // issue side (EX stage -> controller)
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic            in_w;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic [4:0]      in_rd;

    // result side (controller -> writeback)
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;

    // multiplier side
    logic            m_valid;
    logic [1:0]      m_signed;
    logic            m_w;
    logic [XLEN-1:0] m_mul1;
    logic [XLEN-1:0] m_mul2;
    logic            m_ready;
    logic            m_out_valid;
    logic [XLEN-1:0] m_result_h;
    logic [XLEN-1:0] m_result_l;

    modport slave (
        input  in_valid, in_op, in_w, in_src1, in_src2, in_rd,
        output in_ready,
        output out_valid, out_data, out_rd,
        input  out_ready,
        output m_valid, m_signed, m_w, m_mul1, m_mul2,
        input  m_ready, m_out_valid, m_result_h, m_result_l
    );

    modport master (
        output in_valid, in_op, in_w, in_src1, in_src2, in_rd,
        input  in_ready,
        input  out_valid, out_data, out_rd,
        output out_ready,
        input  m_valid, m_signed, m_w, m_mul1, m_mul2,
        output m_ready, m_out_valid, m_result_h, m_result_l
    );

endinterface

// File: rtl/ysyx_22041071_mul_ctrl.sv
// Sequences one RV64M multiply through an external multiplier and hands the rd value to writeback.
// Latency: 1 issue cycle + multiplier latency + 1 to out_valid; zero-operand/illegal ops respond the cycle after accept.
// Backpressure: one op in flight; in_ready only in IDLE with m_ready; result held in RESP until out_ready; flush drops it.
// Ports: clk, reset (sync, active-high), flush, busy (stall = not IDLE), bus (issue/result/multiplier bundle, slave view).
module ysyx_22041071_mul_ctrl
    import ysyx_22041071_mul_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    output logic                     busy,
    ysyx_22041071_mul_ctrl_if.slave  bus
);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            w_q, w_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            in_rdy;
    logic            bypass;

    // flush gates acceptance so a killed instruction can never slip in
    assign in_rdy = (state_q == ST_IDLE) && bus.m_ready && !flush;

    // Ops that need no multiplier: illegal encodings and any zero operand.
    assign bypass = !op_legal(bus.in_op, bus.in_w)
                 || is_zero(bus.in_w, bus.in_src1)
                 || is_zero(bus.in_w, bus.in_src2);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        w_d     = w_q;
        rd_d    = rd_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_rdy) begin
                    op_d   = bus.in_op;
                    w_d    = bus.in_w;
                    rd_d   = bus.in_rd;
                    src1_d = bus.in_src1;
                    src2_d = bus.in_src2;
                    if (bypass) begin
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // The multiplier cannot be aborted: a flush waits out its product in DRAIN,
                // unless that product is arriving right now.
                if (flush) begin
                    state_d = bus.m_out_valid ? ST_IDLE : ST_DRAIN;
                end else if (bus.m_out_valid) begin
                    data_d  = sel_result(op_q, w_q, bus.m_result_h, bus.m_result_l);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush || bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.m_out_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            w_q     <= 1'b0;
            rd_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            rd_q    <= rd_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            data_q  <= data_d;
        end
    end

    // Multiplier inputs come straight from the operand registers, which only load on
    // accept, so they are stable for the whole BUSY window as the sign logic requires.
    assign bus.m_valid   = (state_q == ST_BUSY);
    assign bus.m_signed  = signed_sel(op_q);
    assign bus.m_w       = w_q;
    assign bus.m_mul1    = src1_q;
    assign bus.m_mul2    = src2_q;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == ST_RESP);
    assign bus.out_data  = data_q;
    assign bus.out_rd    = rd_q;

    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041071_mul_ctrl.sv
module tb_ysyx_22041071_mul_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;

    ysyx_22041071_mul_ctrl_if bus();

    ysyx_22041071_mul_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- multiplier emulation ----------------
    // Samples the operands the first negedge m_valid is seen, then returns the
    // full product mult_lat negedges later as a one-cycle m_out_valid pulse.
    int          mult_lat = 3;
    int          m_starts = 0;
    int          mv_gap   = 0;
    int          op_chg   = 0;
    bit          running  = 0;
    int          cnt      = 0;
    logic [63:0] cap1, cap2;
    logic [1:0]  cap_sgn;
    logic        cap_w;
    logic [1:0]  last_sgn;
    logic [127:0] e1, e2, full;

    always @(negedge clk) begin
        bus.m_out_valid = 1'b0;
        if (reset) begin
            running = 0;
            bus.m_result_h = '0;
            bus.m_result_l = '0;
        end else if (running) begin
            if (!bus.m_valid) mv_gap++;
            else if (bus.m_mul1 !== cap1 || bus.m_mul2 !== cap2 ||
                     bus.m_signed !== cap_sgn || bus.m_w !== cap_w) op_chg++;
            cnt--;
            if (cnt == 0) begin
                e1 = cap_sgn[1] ? {{64{cap1[63]}}, cap1} : {64'b0, cap1};
                e2 = cap_sgn[0] ? {{64{cap2[63]}}, cap2} : {64'b0, cap2};
                full = e1 * e2;
                bus.m_result_h  = full[127:64];
                bus.m_result_l  = full[63:0];
                bus.m_out_valid = 1'b1;
                running = 0;
            end
        end else if (bus.m_valid) begin
            running  = 1;
            cnt      = mult_lat;
            cap1     = bus.m_mul1;
            cap2     = bus.m_mul2;
            cap_sgn  = bus.m_signed;
            cap_w    = bus.m_w;
            last_sgn = bus.m_signed;
            m_starts++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  p32;
        if (op > 3'd3 || (w && op != 3'd0)) return 64'd0;
        case (op)
            3'd0: begin
                if (w) begin
                    p32 = {32'b0, a[31:0]} * {32'b0, b[31:0]};
                    return {{32{p32[31]}}, p32[31:0]};
                end
                p = {64'b0, a} * {64'b0, b};
                return p[63:0];
            end
            3'd1: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            3'd2: p = {{64{a[63]}}, a} * {64'b0, b};
            default: p = {64'b0, a} * {64'b0, b};
        endcase
        return p[127:64];
    endfunction

    // ---------------- drivers (start and end on a negedge) ----------------
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         output bit ok, output int waited);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_w     = w;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_rd    = rd;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output logic [63:0] d, output logic [4:0] r,
                           output int lat, output bit ok);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        ok = bus.out_valid;
        d  = bus.out_data;
        r  = bus.out_rd;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.out_data !== 64'd0) begin fails++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        tests++; if (bus.out_rd !== 5'd0) begin fails++; $display("FAIL reset_out_rd got %0d want 0", bus.out_rd); end
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        bus.m_ready = 1'b0;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL m_ready_gate got %b want 0", bus.in_ready); end
        bus.m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  v_op  [5];
        logic        v_w   [5];
        logic [63:0] v_a   [5];
        logic [63:0] v_b   [5];
        logic [63:0] v_exp [5];
        logic [1:0]  v_sgn [5];
        bit ok, ok2;
        int wt, lat;
        logic [63:0] d;
        logic [4:0] r;
        v_op[0] = 3'd0; v_w[0] = 1'b0; v_a[0] = 64'd3;                  v_b[0] = 64'hFFFF_FFFF_FFFF_FFFB;
        v_exp[0] = 64'hFFFF_FFFF_FFFF_FFF1; v_sgn[0] = 2'b11;
        v_op[1] = 3'd3; v_w[1] = 1'b0; v_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        v_exp[1] = 64'hFFFF_FFFF_FFFF_FFFE; v_sgn[1] = 2'b00;
        v_op[2] = 3'd0; v_w[2] = 1'b1; v_a[2] = 64'h0000_0000_8000_0000; v_b[2] = 64'd2;
        v_exp[2] = 64'h0;                   v_sgn[2] = 2'b11;
        v_op[3] = 3'd0; v_w[3] = 1'b1; v_a[3] = 64'h0000_0000_7FFF_FFFF; v_b[3] = 64'd2;
        v_exp[3] = 64'hFFFF_FFFF_FFFF_FFFE; v_sgn[3] = 2'b11;
        v_op[4] = 3'd2; v_w[4] = 1'b0; v_a[4] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[4] = 64'd2;
        v_exp[4] = 64'hFFFF_FFFF_FFFF_FFFF; v_sgn[4] = 2'b10;
        mult_lat = 4;
        mv_gap = 0;
        for (int i = 0; i < 5; i++) begin
            issue(v_op[i], v_w[i], v_a[i], v_b[i], 5'(i + 1), ok, wt);
            collect(d, r, lat, ok2);
            tests++; if (!ok || !ok2) begin fails++; $display("FAIL dir%0d_timeout issue=%0d result=%0d want 1 1", i, ok, ok2); end
            tests++; if (d !== v_exp[i]) begin fails++; $display("FAIL dir%0d_data got %h want %h", i, d, v_exp[i]); end
            tests++; if (last_sgn !== v_sgn[i]) begin fails++; $display("FAIL dir%0d_m_signed got %b want %b", i, last_sgn, v_sgn[i]); end
        end
        tests++; if (mv_gap !== 0) begin fails++; $display("FAIL dir_m_valid_gap got %0d want 0", mv_gap); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic w, legal, zero, bypass;
        logic [63:0] a, b, exp_d, d;
        logic [4:0] rd, r;
        bit ok, ok2;
        int wt, lat, st0, exp_lat;
        op_chg = 0;
        mv_gap = 0;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            w  = (op == 3'd0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) a = w ? {a[63:32], 32'b0} : 64'b0;
            if ($urandom_range(0, 5) == 0) b = w ? {b[63:32], 32'b0} : 64'b0;
            mult_lat = $urandom_range(1, 6);
            legal   = (op < 3'd4) && !(w && op != 3'd0);
            zero    = w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0);
            bypass  = !legal || zero;
            exp_d   = legal ? ref_mul(op, w, a, b) : 64'd0;
            exp_lat = bypass ? 0 : mult_lat + 1;
            st0     = m_starts;
            issue(op, w, a, b, rd, ok, wt);
            collect(d, r, lat, ok2);
            tests++; if (!ok || !ok2) begin fails++; $display("FAIL rnd%0d_timeout issue=%0d result=%0d want 1 1", i, ok, ok2); end
            tests++; if (d !== exp_d) begin fails++; $display("FAIL rnd%0d_data op=%0d w=%0d a=%h b=%h got %h want %h", i, op, w, a, b, d, exp_d); end
            tests++; if (r !== rd) begin fails++; $display("FAIL rnd%0d_rd got %0d want %0d", i, r, rd); end
            tests++; if (lat != exp_lat) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat); end
            tests++; if ((m_starts - st0) != (bypass ? 0 : 1)) begin fails++; $display("FAIL rnd%0d_m_starts got %0d want %0d", i, m_starts - st0, bypass ? 0 : 1); end
            if (i > 0) begin
                tests++; if (wt != 0) begin fails++; $display("FAIL rnd%0d_back_to_back waited %0d want 0", i, wt); end
            end
        end
        tests++; if (op_chg != 0) begin fails++; $display("FAIL rnd_operand_stability got %0d want 0", op_chg); end
        tests++; if (mv_gap != 0) begin fails++; $display("FAIL rnd_m_valid_gap got %0d want 0", mv_gap); end
    endtask

    task automatic test_bypass_stall();
        bit ok;
        int wt, st0, bad;
        st0 = m_starts;
        bad = 0;
        issue(3'd0, 1'b0, {$urandom(), $urandom()} | 64'd1, 64'd0, 5'd7, ok, wt);
        tests++; if (!ok) begin fails++; $display("FAIL stall_issue got %0d want 1", ok); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd0 || bus.out_rd !== 5'd7 ||
                bus.in_ready !== 1'b0 || bus.m_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d got ov=%b d=%h rd=%0d ir=%b mv=%b want 1 0 7 0 0",
                         i, bus.out_valid, bus.out_data, bus.out_rd, bus.in_ready, bus.m_valid);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready); end
        tests++; if (m_starts != st0) begin fails++; $display("FAIL stall_m_starts got %0d want %0d", m_starts - st0, 0); end
    endtask

    task automatic test_flush_busy();
        bit ok, ok2, seen_out, seen_rdy;
        int wt, n, lat, st0;
        logic [63:0] d;
        logic [4:0] r;
        mult_lat = 15;
        issue(3'd0, 1'b0, 64'd5, 64'd9, 5'd3, ok, wt);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++; if (bus.m_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL drain_entry got mv=%b busy=%b want 0 1", bus.m_valid, busy); end
        seen_out = 0;
        seen_rdy = 0;
        n = 0;
        while (busy && n < 100) begin
            if (bus.out_valid) seen_out = 1;
            if (bus.in_ready) seen_rdy = 1;
            @(negedge clk);
            n++;
        end
        tests++; if (n != mult_lat + 1 - 10) begin fails++; $display("FAIL drain_length got %0d want %0d", n, mult_lat + 1 - 10); end
        tests++; if (seen_out || seen_rdy) begin fails++; $display("FAIL drain_quiet got out_valid=%0d in_ready=%0d want 0 0", seen_out, seen_rdy); end
        tests++; if (running) begin fails++; $display("FAIL drain_product_pending got %0d want 0", running); end
        mult_lat = 3;
        st0 = m_starts;
        issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd9, ok, wt);
        collect(d, r, lat, ok2);
        tests++; if (!ok || !ok2 || d !== 64'd42 || r !== 5'd9) begin fails++; $display("FAIL after_flush_mul got ok=%0d%0d d=%0d rd=%0d want 11 42 9", ok, ok2, d, r); end
        tests++; if (m_starts - st0 != 1) begin fails++; $display("FAIL after_flush_starts got %0d want 1", m_starts - st0); end
    endtask

    task automatic test_flush_resp();
        bit ok;
        int wt;
        issue(3'd6, 1'b0, 64'd11, 64'd13, 5'd4, ok, wt);
        tests++; if (!ok || bus.out_valid !== 1'b1 || bus.out_data !== 64'd0) begin fails++; $display("FAIL illegal_resp got ok=%0d ov=%b d=%h want 1 1 0", ok, bus.out_valid, bus.out_data); end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_resp got ov=%b busy=%b want 0 0", bus.out_valid, busy); end
        bus.in_valid = 1'b1;
        bus.in_op = 3'd0;
        bus.in_w = 1'b0;
        bus.in_src1 = 64'd2;
        bus.in_src2 = 64'd3;
        flush = 1'b1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tests++; if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin fails++; $display("FAIL flush_idle_accept got busy=%b mv=%b want 0 0", busy, bus.m_valid); end
    endtask

    task automatic test_reset_busy();
        bit ok, ok2;
        int wt, lat;
        logic [63:0] d;
        logic [4:0] r;
        mult_lat = 5;
        issue(3'd0, 1'b0, 64'd3, 64'd4, 5'd12, ok, wt);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_rd !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid_busy got busy=%b mv=%b ov=%b rd=%0d want 0 0 0 0", busy, bus.m_valid, bus.out_valid, bus.out_rd);
        end
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, ok, wt);
        collect(d, r, lat, ok2);
        tests++; if (!ok || !ok2 || d !== 64'd1) begin fails++; $display("FAIL after_reset_mulhu got ok=%0d%0d d=%h want 11 1", ok, ok2, d); end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 3'd0;
        bus.in_w = 1'b0;
        bus.in_src1 = '0;
        bus.in_src2 = '0;
        bus.in_rd = '0;
        bus.out_ready = 1'b0;
        bus.m_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_bypass_stall();
        test_flush_busy();
        test_flush_resp();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22041071_mul_ctrl.md
YSYX_22041071_MUL_CTRL -- requirements
Module: ysyx_22041071_mul_ctrl

Interface
REQ-001 SHALL: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL: flush  in  1  kill the in-flight or pending op; drop any result not yet handed off.
REQ-004 SHALL: in_valid / in_ready  in/out  1/1  issue handshake from the EX stage; transfer when both are high.
REQ-005 SHALL: in_op  in  3  funct3 select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes illegal.
REQ-006 SHALL: in_w  in  1  RV64 word form (MULW); legal only with in_op=000.
REQ-007 SHALL: in_src1, in_src2  in  64 each  rs1 and rs2 operand values.
REQ-008 SHALL: in_rd  in  5  destination register tag, returned with the result.
REQ-009 SHALL: out_valid / out_ready  out/in  1/1  result handshake to the writeback side.
REQ-010 SHALL: out_data  out  64  final rd value; out_rd  out  5  tag of that result.
REQ-011 SHALL: m_valid, m_signed[1:0], m_w, m_mul1[63:0], m_mul2[63:0]  out  drive the multiplier inputs.
REQ-012 SHALL: m_ready, m_out_valid, m_result_h[63:0], m_result_l[63:0]  in  multiplier status and product.
REQ-013 SHALL: busy  out  1  high in any state other than IDLE; used as the pipeline stall.

Function
REQ-014 SHALL: implement FSM states IDLE, BUSY, RESP, DRAIN.
REQ-015 SHALL: in_ready = (state==IDLE) & m_ready & ~flush.
REQ-016 SHALL: on accept, register op, w, rd, src1 and src2, then move to BUSY.
- Exception: if either operand is zero (low 32 bits only when w=1), move straight to RESP with out_data=0 and never start the multiplier.
REQ-017 SHALL: m_valid = (state==BUSY); m_mul1, m_mul2, m_signed and m_w SHALL stay constant from BUSY entry through the m_out_valid cycle.
- Reason: the multiplier derives its sign correction combinationally from m_valid and the operands.
REQ-018 SHALL: map m_signed as follows:
- MUL, MULH: 2'b11
- MULHSU: 2'b10 (src1 signed, src2 unsigned)
- MULHU: 2'b00
- 2'b01 is never driven.
REQ-019 SHALL: in BUSY, on m_out_valid, capture the selected result into the output register and move to RESP. m_valid is low from the next cycle.
REQ-020 SHALL: select the result as follows:
- MUL, w=0: m_result_l
- MULW: sign-extend m_result_l[31:0] to 64 bits
- MULH, MULHSU, MULHU: m_result_h
REQ-021 SHALL: in RESP, out_valid=1 and out_data/out_rd stay stable until out_ready; then return to IDLE. A back-to-back accept is allowed in the following cycle.
REQ-022 SHALL: on flush in BUSY, move to DRAIN with m_valid forced low, because the multiplier cannot be aborted.
REQ-023 SHALL: in DRAIN, wait for m_out_valid, discard the product, then go to IDLE with out_valid never asserted.
REQ-024 SHALL: on flush in RESP, go to IDLE and deassert out_valid on the next cycle; flush takes priority over a same-cycle out_ready.
REQ-025 SHALL: on flush with in_valid in IDLE, accept nothing; flush wins.
REQ-026 SHALL: for an illegal in_op, complete in RESP with out_data=0 and never start the multiplier.
REQ-027 SHALL: keep latency data-independent except for the zero bypass.
- Normal path: 1 issue cycle + multiplier latency + 1 cycle to out_valid.
- Zero bypass: out_valid on the cycle after accept.

Reset
REQ-028 SHALL: reset forces state=IDLE and clears all registers.
- Resulting outputs: out_valid=0, out_data=0, out_rd=0, m_valid=0, busy=0.
REQ-029 SHALL: reset mid-BUSY returns to IDLE immediately; the multiplier is reset by the same signal.

Structure
REQ-030 SHALL: place the funct3 op codes, the m_signed encodings and the FSM state encodings in the shared define file next to the data-bus width macro.
REQ-031 SHALL: instantiate no sub-module; the multiplier sits beside this block at the EX level, and a separate result-select function is optional.

Verification
REQ-032 SHALL: MUL, src1=3, src2=0xFFFF_FFFF_FFFF_FFFB -> out_data=0xFFFF_FFFF_FFFF_FFF1; m_valid high continuously until m_out_valid.
REQ-033 SHALL: MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF -> out_data=0xFFFF_FFFF_FFFF_FFFE; m_signed=2'b00.
REQ-034 SHALL: MULW, src1=0x0000_0000_8000_0000, src2=2 -> out_data=0x0000_0000_0000_0000. MULW, src1=0x7FFF_FFFF, src2=2 -> out_data=0xFFFF_FFFF_FFFF_FFFE.
REQ-035 SHALL: MULHSU, src1=-1, src2=2 -> out_data=0xFFFF_FFFF_FFFF_FFFF; m_signed=2'b10.
REQ-036 SHALL: flush 10 cycles after accept -> DRAIN until m_out_valid, no out_valid, in_ready low until IDLE; the next MUL 6*7 -> out_data=42.
REQ-037 SHALL: src2=0 with out_ready held low for 5 cycles -> m_valid never asserted; out_valid high from cycle 1 with out_data=0 held stable; in_ready low until the handshake completes.
